sid_pot_sense: RTL and testbench

//  POT pad front end, placed directly upstream of the POTX/POTY counter stage.

---
 rtl/sid_pot_sense.sv | 129 ++++++++++++
 tb/tb_sid_pot_sense.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_pot_sense.sv
// POT pad front end: sync, optional glitch filter, sticky charged flags.
// Optional filter enabled by defining SID_POT_GLITCH_FILTER_EN.

package sid;

  localparam int PHI1      = 0;
  localparam int PHI1_PHI2 = 1;
  localparam int PHI2      = 2;
  localparam int PHI2_PHI1 = 3;

  typedef logic [3:0] phase_t;

endpackage

module sid_pot_sense #(
  parameter int FILT_LEN  = 4,
  parameter int BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  sid::phase_t phase,
  input  logic [1:0]  pot_pad_i,
  input  logic        discharge,
  output logic [1:0]  pad_oe,
  output logic [1:0]  charged
);

  import sid::*;

  typedef enum logic [1:0] {
    S_DIS,
    S_BLANK,
    S_SENSE,
    S_LATCH
  } st_t;

  logic [1:0] sync1;
  logic [1:0] sync_q;
  logic       strobe;
  logic       phase_unused;

  assign strobe       = phase[PHI1_PHI2];
  assign phase_unused = ^phase;

`ifndef SID_POT_GLITCH_FILTER_EN
  localparam int FILT_LEN_UNUSED = FILT_LEN;
`endif

  // two-flop synchroniser for both pad comparators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync_q <= '0;
    end else begin
      sync1  <= pot_pad_i;
      sync_q <= sync1;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_ch

    st_t        state;
    logic [2:0] blank_cnt;
    logic       lat;
    logic       qual;

`ifdef SID_POT_GLITCH_FILTER_EN
    logic [3:0] cnt;

    // run length of consecutive high samples while sensing
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (state != S_SENSE || !sync_q[i]) begin
        cnt <= '0;
      end else if (cnt != 4'(FILT_LEN)) begin
        cnt <= cnt + 4'd1;
      end
    end

    assign qual = (cnt == 4'(FILT_LEN - 1)) & sync_q[i];
`else
    assign qual = sync_q[i];
`endif

    // discharge / blank / sense / latched sequencing
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= S_DIS;
        blank_cnt <= '0;
        lat       <= 1'b0;
      end else if (discharge) begin
        state <= S_DIS;
        lat   <= 1'b0;
      end else begin
        unique case (state)
          S_DIS: begin
            if (BLANK_CYC == 0) begin
              state <= S_SENSE;
            end else begin
              state     <= S_BLANK;
              blank_cnt <= 3'(BLANK_CYC);
            end
          end
          S_BLANK: begin
            if (strobe) begin
              blank_cnt <= blank_cnt - 3'd1;
              if (blank_cnt == 3'd1) state <= S_SENSE;
            end
          end
          S_SENSE: begin
            if (qual) begin
              state <= S_LATCH;
              lat   <= 1'b1;
            end
          end
          S_LATCH: begin
            state <= S_LATCH;
          end
        endcase
      end
    end

    assign pad_oe[i]  = discharge | (state == S_DIS);
    assign charged[i] = lat;

  end

endmodule

// File: tb/tb_sid_pot_sense.sv
// Self-checking bench for sid_pot_sense.
// Directed scenarios plus random stimulus against a behavioural model.

module tb_sid_pot_sense;

  import sid::*;

  localparam int FILT_LEN  = 4;
  localparam int BLANK_CYC = 2;
`ifdef SID_POT_GLITCH_FILTER_EN
  localparam int F = FILT_LEN;
`else
  localparam int F = 1;
`endif
  localparam int LAT = 2 + F;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  phase_t     phase = '0;
  logic [1:0] pot_pad_i = '0;
  logic       discharge = 1'b0;
  logic [1:0] pad_oe;
  logic [1:0] charged;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sid_pot_sense #(
    .FILT_LEN (FILT_LEN),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .phase    (phase),
    .pot_pad_i(pot_pad_i),
    .discharge(discharge),
    .pad_oe   (pad_oe),
    .charged  (charged)
  );

  // behavioural model: pad delay line, strobes still to
  // wait out, run of high samples, sticky flag
  logic [1:0] m_p1, m_p2;
  logic       m_dis[2];
  int         m_left[2];
  int         m_run[2];
  logic       m_lat[2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_p1 = '0;
      m_p2 = '0;
      for (int i = 0; i < 2; i++) begin
        m_dis[i]  = 1'b1;
        m_left[i] = 0;
        m_run[i]  = 0;
        m_lat[i]  = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (discharge) begin
          m_dis[i] = 1'b1;
          m_lat[i] = 1'b0;
          m_run[i] = 0;
        end else if (m_dis[i]) begin
          m_dis[i]  = 1'b0;
          m_left[i] = BLANK_CYC;
          m_run[i]  = 0;
        end else if (m_left[i] > 0) begin
          if (phase[PHI1_PHI2]) m_left[i]--;
          m_run[i] = 0;
        end else if (!m_lat[i]) begin
          m_run[i] = m_p2[i] ? m_run[i] + 1 : 0;
          if (m_run[i] >= F) m_lat[i] = 1'b1;
        end
      end
      m_p2 = m_p1;
      m_p1 = pot_pad_i;
    end
  end

  function automatic logic [1:0] exp_chg();
    return {m_lat[1], m_lat[0]};
  endfunction

  function automatic logic [1:0] exp_oe();
    return {discharge | m_dis[1], discharge | m_dis[0]};
  endfunction

  function automatic logic sensing(input int i);
    return !m_dis[i] && m_left[i] == 0;
  endfunction

  task automatic tick(input logic [1:0] pad,
                      input logic dis,
                      input logic stb);
    @(negedge clk);
    pot_pad_i = pad;
    discharge = dis;
    phase = '0;
    phase[PHI1_PHI2] = stb;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    pot_pad_i = 2'b11;
    discharge = 1'b0;
    #12;
    rst = 1'b1;
    #1;
    checks++;
    if (pad_oe !== 2'b11 || charged !== 2'b00) begin
      errors++;
      $display("FAIL reset_async: oe=%b chg=%b want 11/00",
               pad_oe, charged);
    end
    tick(2'b11, 1'b1, 1'b1);
    tick(2'b11, 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(2'b11, 1'b1, 1'b1);
      checks++;
      if (pad_oe !== 2'b11 || charged !== 2'b00) begin
        errors++;
        $display("FAIL reset_release: oe=%b chg=%b want 11/00",
                 pad_oe, charged);
      end
    end
  endtask

  task automatic enter_sense(input logic [1:0] pad);
    tick(pad, 1'b1, 1'b0);
    tick(pad, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) tick(pad, 1'b0, (k % 3) == 0);
  endtask

  task automatic test_basic();
    int  n;
    bit  hit;
    enter_sense(2'b00);
    checks++;
    if (charged !== 2'b00 || pad_oe !== 2'b00) begin
      errors++;
      $display("FAIL basic_idle: oe=%b chg=%b want 00/00",
               pad_oe, charged);
    end
    n = 0;
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      tick(2'b01, 1'b0, 1'b0);
      n++;
      if (charged[0] === 1'b1) hit = 1;
      checks++;
      if (charged !== exp_chg() || charged[1] !== 1'b0) begin
        errors++;
        $display("FAIL basic_track: chg=%b model=%b",
                 charged, exp_chg());
      end
    end
    checks++;
    if (!hit || n != LAT) begin
      errors++;
      $display("FAIL basic_latency: got %0d clk (hit=%0d) want %0d",
               n, hit, LAT);
    end
    for (int k = 0; k < 3; k++) tick(2'b00, 1'b0, 1'b1);
    checks++;
    if (charged !== 2'b01) begin
      errors++;
      $display("FAIL basic_fall_hold: chg=%b want 01", charged);
    end
  endtask

  task automatic test_glitch();
    enter_sense(2'b00);
    for (int k = 0; k < F - 1; k++) tick(2'b10, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick(2'b00, 1'b0, 1'b0);
      checks++;
      if (charged !== 2'b00) begin
        errors++;
        $display("FAIL glitch_ignored: chg=%b want 00", charged);
      end
    end
    for (int k = 0; k < F + 3; k++) begin
      tick(2'b10, 1'b0, 1'b0);
      checks++;
      if (charged !== exp_chg()) begin
        errors++;
        $display("FAIL glitch_track: chg=%b model=%b",
                 charged, exp_chg());
      end
    end
    checks++;
    if (charged !== 2'b10) begin
      errors++;
      $display("FAIL glitch_qualify: chg=%b want 10", charged);
    end
  endtask

  task automatic test_blanking();
    int entry;
    int latch;
    entry = -1;
    latch = -1;
    for (int k = 0; k < 4; k++) tick(2'b01, 1'b1, 1'b1);
    for (int k = 0; k < 24; k++) begin
      tick(2'b01, 1'b0, (k % 3) == 1);
      if (entry < 0 && sensing(0)) entry = k;
      if (latch < 0 && charged[0] === 1'b1) latch = k;
      checks++;
      if (charged !== exp_chg() || pad_oe !== exp_oe()) begin
        errors++;
        $display("FAIL blank_track: oe=%b chg=%b model %b/%b",
                 pad_oe, charged, exp_oe(), exp_chg());
      end
      if (!sensing(0)) begin
        checks++;
        if (charged[0] !== 1'b0) begin
          errors++;
          $display("FAIL blank_ignore: chg0=%b want 0", charged[0]);
        end
      end
    end
    checks++;
    if (entry < 0 || latch - entry != F) begin
      errors++;
      $display("FAIL blank_latency: entry=%0d latch=%0d want gap %0d",
               entry, latch, F);
    end
  endtask

  task automatic test_priority();
    enter_sense(2'b00);
    for (int k = 0; k < LAT - 1; k++) tick(2'b01, 1'b0, 1'b0);
    checks++;
    if (charged !== 2'b00) begin
      errors++;
      $display("FAIL prio_pre: chg=%b want 00", charged);
    end
    @(negedge clk);
    discharge = 1'b1;
    phase = '0;
    #1;
    checks++;
    if (pad_oe !== 2'b11) begin
      errors++;
      $display("FAIL prio_oe_same_cycle: oe=%b want 11", pad_oe);
    end
    @(posedge clk);
    #1;
    checks++;
    if (charged !== 2'b00 || pad_oe !== 2'b11) begin
      errors++;
      $display("FAIL prio_discharge_wins: oe=%b chg=%b want 11/00",
               pad_oe, charged);
    end
  endtask

  task automatic test_mid_reset();
    enter_sense(2'b11);
    for (int k = 0; k < LAT + 1; k++) tick(2'b11, 1'b0, 1'b0);
    checks++;
    if (charged !== 2'b11) begin
      errors++;
      $display("FAIL midrst_pre: chg=%b want 11", charged);
    end
    @(negedge clk);
    discharge = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (pad_oe !== 2'b11 || charged !== 2'b00) begin
      errors++;
      $display("FAIL midrst_async: oe=%b chg=%b want 11/00",
               pad_oe, charged);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(2'b00, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0] pad;
    logic       dis;
    int         hold;
    pad = '0;
    hold = 0;
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < 2; i++)
        if ($urandom_range(0, 3) == 0) pad[i] = ~pad[i];
      if (hold > 0) begin
        dis = 1'b1;
        hold--;
      end else begin
        dis = 1'b0;
        if ($urandom_range(0, 29) == 0) hold = $urandom_range(1, 4);
      end
      tick(pad, dis, $urandom_range(0, 2) == 0);
      checks++;
      if (charged !== exp_chg() || pad_oe !== exp_oe()) begin
        errors++;
        $display("FAIL random_%0d: oe=%b chg=%b model %b/%b",
                 k, pad_oe, charged, exp_oe(), exp_chg());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_blanking();
    test_priority();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
